// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode enum and datapath width shared by the ALU, its interface and the control decoder
package alu_pkg;
  localparam int ALU_W = 32;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_DIV = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR  = 3'd5,
    ALU_XOR = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;
endpackage

// File: rtl/arithmetic_logic_unit_if.sv
// arithmetic_logic_unit_if: ALU bus; master drives inpReadData1/inpData2/aluControl, slave returns aluResult/outZero/outDivZero
interface arithmetic_logic_unit_if;
  import alu_pkg::*;
  logic [ALU_W-1:0] inpReadData1;
  logic [ALU_W-1:0] inpData2;
  logic [2:0] aluControl;
  logic [ALU_W-1:0] aluResult;
  logic outZero;
  logic outDivZero;
  modport master(output inpReadData1, inpData2, aluControl, input aluResult, outZero, outDivZero);
  modport slave(input inpReadData1, inpData2, aluControl, output aluResult, outZero, outDivZero);
endinterface

// File: rtl/alu_signed_divider.sv
// alu_signed_divider: combinational signed a/b (truncating) via restoring division on magnitudes; ports a, b in, q out
module alu_signed_divider
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] q
);
  logic [ALU_W-1:0] ma, mb, quo;
  logic [ALU_W:0] rem;
  assign ma = a[ALU_W-1] ? -a : a;
  assign mb = b[ALU_W-1] ? -b : b;
  always_comb begin
    rem = '0;
    quo = '0;
    for (int i = ALU_W - 1; i >= 0; i--) begin
      rem = {rem[ALU_W-1:0], ma[i]};
      quo[i] = rem >= {1'b0, mb};
      rem = quo[i] ? rem - {1'b0, mb} : rem;
    end
  end
  assign q = (b == '0) ? '1 :
             (a == {1'b1, {(ALU_W-1){1'b0}}} && b == '1) ? a :
             (a[ALU_W-1] ^ b[ALU_W-1]) ? -quo : quo;
endmodule

// File: rtl/arithmetic_logic_unit.sv
// arithmetic_logic_unit: combinational 32-bit ALU with sticky divide-by-zero flag; ports clk, rst_n, bus (slave)
module arithmetic_logic_unit
  import alu_pkg::*;
(
  input logic clk,
  input logic rst_n,
  arithmetic_logic_unit_if.slave bus
);
  logic [ALU_W-1:0] a, b, quo, res;
  logic div_zero;
  assign a = bus.inpReadData1;
  assign b = bus.inpData2;
  alu_signed_divider u_div (.a(a), .b(b), .q(quo));
  always_comb begin
    res = '0;
    case (alu_op_e'(bus.aluControl))
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_MUL: res = $signed(a) * $signed(b);
      ALU_DIV: res = quo;
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      ALU_SLT: res = {{(ALU_W-1){1'b0}}, $signed(a) < $signed(b)};
      default: res = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div_zero <= 1'b0;
    else if (bus.aluControl == ALU_DIV && b == '0) div_zero <= 1'b1;
  assign bus.aluResult = res;
  assign bus.outZero = res == '0;
  assign bus.outDivZero = div_zero;
endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// tb_arithmetic_logic_unit: directed-vector self-checking bench for arithmetic_logic_unit
module tb_arithmetic_logic_unit;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  arithmetic_logic_unit_if bus ();
  arithmetic_logic_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.aluControl = op;
    bus.inpReadData1 = a;
    bus.inpData2 = b;
  endtask
  task automatic run(input string tag, input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp);
    @(negedge clk);
    drive(op, a, b);
    #1;
    check(tag, bus.aluResult, exp);
    check({tag, "_zero"}, {31'b0, bus.outZero}, {31'b0, exp == 32'd0});
  endtask
  initial begin
    drive(ALU_DIV, 32'd5, 32'd0);
    #12;
    check("rst_flag", {31'b0, bus.outDivZero}, 32'd0);
    check("rst_result", bus.aluResult, 32'hFFFF_FFFF);
    drive(ALU_ADD, 32'd0, 32'd0);
    rst_n = 1'b1;
    run("add", ALU_ADD, 32'd8, 32'd8, 32'd16);
    run("sub1", ALU_SUB, 32'd12, 32'd11, 32'd1);
    run("sub2", ALU_SUB, 32'd12, -32'd12, 32'd24);
    run("sub3", ALU_SUB, -32'd10, 32'd11, 32'hFFFF_FFEB);
    run("sub4", ALU_SUB, -32'd12, -32'd12, 32'd0);
    run("mul1", ALU_MUL, 32'd8, 32'd4, 32'd32);
    run("mul2", ALU_MUL, 32'd8, -32'd4, 32'hFFFF_FFE0);
    run("mul3", ALU_MUL, -32'd8, 32'd4, 32'hFFFF_FFE0);
    run("mul4", ALU_MUL, -32'd8, -32'd4, 32'd32);
    run("div1", ALU_DIV, 32'd8, 32'd4, 32'd2);
    run("div2", ALU_DIV, 32'd8, -32'd4, 32'hFFFF_FFFE);
    run("div3", ALU_DIV, -32'd8, 32'd4, 32'hFFFF_FFFE);
    run("div4", ALU_DIV, -32'd8, -32'd4, 32'd2);
    run("div5", ALU_DIV, -32'd7, 32'd2, 32'hFFFF_FFFD);
    run("div6", ALU_DIV, 32'd100, 32'd7, 32'd14);
    run("and", ALU_AND, 32'd8, 32'd4, 32'd0);
    run("or", ALU_OR, 32'd8, 32'd4, 32'd12);
    run("xor", ALU_XOR, 32'd8, 32'd4, 32'd12);
    run("xor2", ALU_XOR, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000);
    run("slt1", ALU_SLT, -32'd1, 32'd1, 32'd1);
    run("slt2", ALU_SLT, 32'd1, -32'd1, 32'd0);
    run("slt3", ALU_SLT, 32'd5, 32'd5, 32'd0);
    check("flag_clear", {31'b0, bus.outDivZero}, 32'd0);
    run("div0", ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    check("flag_before_edge", {31'b0, bus.outDivZero}, 32'd0);
    @(posedge clk);
    #1;
    check("flag_set", {31'b0, bus.outDivZero}, 32'd1);
    run("add_after", ALU_ADD, 32'd1, 32'd2, 32'd3);
    @(posedge clk);
    #1;
    check("flag_sticky", {31'b0, bus.outDivZero}, 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("flag_async_clr", {31'b0, bus.outDivZero}, 32'd0);
    drive(ALU_SUB, 32'd9, 32'd4);
    #1;
    check("result_in_rst", bus.aluResult, 32'd5);
    @(negedge clk);
    rst_n = 1'b1;
    run("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    @(posedge clk);
    #1;
    check("flag_after_ovf", {31'b0, bus.outDivZero}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arithmetic_logic_unit.md
# arithmetic_logic_unit

32-bit integer ALU for the single-cycle MIPS datapath: add, subtract, signed multiply, signed divide, bitwise logic and set-less-than, selected by a 3-bit control code from the ALU control decoder. Operand A comes straight from register-file read port 1. Operand B comes from the ALUSrc mux. The result and zero flag are combinational so the datapath completes in one cycle. A single sticky divide-by-zero status bit is the only clocked state.

## Interface
- No parameters; width fixed at 32 bits.
- One clock; reset is asynchronous and active-low.
- clk  input  1  system clock; used only by the status register.
- rst_n  input  1  asynchronous active-low reset.
- inpReadData1  input  32  operand A, two's complement.
- inpData2  input  32  operand B, two's complement.
- aluControl  input  3  operation select.
- aluResult  output  32  combinational result.
- outZero  output  1  combinational; 1 when aluResult == 0.
- outDivZero  output  1  registered sticky flag; set by a divide with B == 0.

## Operation
- 3'd0 ADD: A + B, wraps modulo 2^32, no overflow flag.
- 3'd1 SUB: A − B, wraps modulo 2^32.
- 3'd2 MUL: signed A × B; aluResult is the low 32 bits of the 64-bit product.
- 3'd3 DIV: signed quotient A / B, truncated toward zero. Remainder is discarded.
  - B == 0: aluResult = 32'hFFFF_FFFF.
  - A == 32'h8000_0000 and B == −1: aluResult = 32'h8000_0000.
- 3'd4 AND: A & B.
- 3'd5 OR: A | B.
- 3'd6 XOR: A ^ B.
- 3'd7 SLT: 32'd1 if signed A < signed B, else 32'd0.
- outZero = (aluResult == 32'd0) for every opcode.
- outDivZero is set on the rising clk edge when aluControl == 3 and B == 0. It stays set until rst_n is asserted.
- X on aluControl is never forwarded as a defined op. The default branch drives aluResult to 0.

## Timing
- aluResult and outZero are purely combinational: zero-cycle latency, no handshake.
- Outputs must settle within 10 ns of any input change in behavioural simulation.
- Reset affects only outDivZero.
  - rst_n low: outDivZero = 0 immediately (asynchronous).
  - aluResult and outZero keep tracking inputs during reset.
- Reset deasserting on the same edge as a divide-by-zero: the flag sets on that edge only if rst_n is already high at the edge.
- No internal pipeline, so reset mid-operation has no other effect.

## Structure
- Package alu_pkg holds:
  - enum alu_op_e (ALU_ADD=0, ALU_SUB=1, ALU_MUL=2, ALU_DIV=3, ALU_AND=4, ALU_OR=5, ALU_XOR=6, ALU_SLT=7);
  - localparam ALU_W = 32.
- The control decoder imports the same package.
- One sub-module, alu_signed_divider, is combinational. It does restoring division on magnitudes and applies the sign afterwards. It implements the B == 0 and overflow rules above.
- Add, subtract, multiply and logic ops stay inline in a single always_comb case.

## Test plan
- ADD 8 + 8 → 16. SUB 12 − 11 → 1. SUB 12 − (−12) → 24. SUB −10 − 11 → 32'hFFFF_FFEB (−21). SUB −12 − (−12) → 0 with outZero = 1.
- MUL:
  - 8 × 4 → 32;
  - 8 × −4 → 32'hFFFF_FFE0;
  - −8 × 4 → 32'hFFFF_FFE0;
  - −8 × −4 → 32.
- DIV:
  - 8/4 → 2;
  - 8/−4 → 32'hFFFF_FFFE;
  - −8/4 → 32'hFFFF_FFFE;
  - −8/−4 → 2;
  - −7/2 → 32'hFFFF_FFFD (−3, truncation toward zero).
- Logic with A = 8, B = 4:
  - AND → 0, outZero = 1;
  - OR → 12;
  - XOR → 12.
- SLT −1 vs 1 → 1. SLT 1 vs −1 → 0, outZero = 1.
- DIV 5/0 → 32'hFFFF_FFFF. outDivZero rises after the next clk edge and stays 1 through later ops. Pulling rst_n low mid-cycle clears it at once. 32'h8000_0000 / −1 → 32'h8000_0000.
